// File: rtl/math_result_fifo_pkg.sv
// Shared definitions for the math result path: result width and the packed
// FIFO entry layout {rmd, q}, used by the upstream and downstream blocks.
package math_result_fifo_pkg;

    localparam int W_DEFAULT     = 32;
    localparam int DEPTH_DEFAULT = 4;

    function automatic int calc_qw(input int w);
        return 2 * w + 4;
    endfunction

    // Entry is {rmd, q}: the remainder bit sits above the quotient.
    function automatic int entry_w(input int w);
        return calc_qw(w) + 1;
    endfunction

endpackage

// File: rtl/math_result_mem.sv
// Result storage: DEPTH x DW register array with one synchronous write port
// and one asynchronous read port.
module math_result_mem #(
    parameter int DW    = 69,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/math_result_fifo.sv
// Show-ahead FIFO turning the expression pipeline's done tick into a
// valid/ready stream. Define MATH_RESULT_FIFO_STATS_EN for odd/drop counters.
module math_result_fifo
    import math_result_fifo_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int QW   = calc_qw(W),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [QW-1:0] in_q,
    input  logic          in_rmd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] out_q,
    output logic          out_rmd,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow
`ifdef MATH_RESULT_FIFO_STATS_EN
    ,
    output logic [15:0]   odd_cnt,
    output logic [15:0]   drop_cnt
`endif
);

    localparam int          EW       = entry_w(W);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_r;
    logic          overflow_r;
    logic [QW-1:0] last_q;
    logic          last_rmd;
    logic [EW-1:0] head;
    logic          push;
    logic          pop;
    logic          drop;

    // Handshake: the head transfers on any edge where out_valid && out_ready;
    // out_ready is ignored while out_valid is low. Upstream cannot stall, so a
    // tick arriving while full without a same-edge pop is dropped.
    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == '0);
    assign out_valid = !empty;
    assign count     = count_r;
    assign overflow  = overflow_r;
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && (!full || pop);
    assign drop      = in_valid && full && !pop;

    math_result_mem #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({in_rmd, in_q}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
            last_q     <= '0;
            last_rmd   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                last_q   <= head[QW-1:0];
                last_rmd <= head[QW];
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            if (drop) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // When empty, keep presenting the most recently consumed head.
    assign out_q   = out_valid ? head[QW-1:0] : last_q;
    assign out_rmd = out_valid ? head[QW]     : last_rmd;

`ifdef MATH_RESULT_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            odd_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (push && in_rmd && (odd_cnt != 16'hFFFF)) begin
                odd_cnt <= odd_cnt + 16'd1;
            end
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
